imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 23 ++
 rtl/imem_loader_release_timer.sv | 30 +++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and small RV32 instruction-encoding helpers used when preparing images.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } loader_state_t;

  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [2:0] F3_SW     = 3'b010;

  // sw rs2, imm(rs1)
  function automatic logic [31:0] sw_enc(input logic [4:0] rs2,
                                         input logic [4:0] rs1,
                                         input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OPC_STORE};
  endfunction

endpackage

// File: rtl/imem_loader_release_timer.sv
// Down-counter that holds the CPU in reset for RELEASE_DELAY cycles after
// the final instruction word has been written.
module reset_release_timer #(
  parameter int RELEASE_DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = (RELEASE_DELAY < 2) ? 1 : $clog2(RELEASE_DELAY + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CW'(RELEASE_DELAY);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Terminal count at 1 so the final HOLD cycle is the one that exits
  assign expired = (cnt <= CW'(1));

endmodule

// File: rtl/imem_loader.sv
// Streams instruction words into instruction memory, then releases the CPU
// from reset after a programmable hold-off.
//
// state   | meaning
// S_IDLE  | waiting for a start pulse, CPU in reset
// S_LOAD  | accepting words and writing them to imem
// S_HOLD  | last word written, counting down before CPU release
// S_RUN   | CPU released, program loaded
// S_ERROR | session exceeded DEPTH words, CPU kept in reset
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    DEPTH         = 256,
  parameter int                    ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                    RELEASE_DELAY = 3
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_start,
  input  logic [DATA_WIDTH-1:0]        i_instr_data,
  input  logic                         i_instr_valid,
  input  logic                         i_instr_last,
  output logic                         o_instr_ready,
  output logic                         o_imem_we,
  output logic [ADDR_WIDTH-1:0]        o_imem_addr,
  output logic [DATA_WIDTH-1:0]        o_imem_wdata,
  output logic                         o_cpu_reset_n,
  output logic                         o_done,
  output logic                         o_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   o_word_count
);

  localparam int                    CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]         DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP    = ADDR_WIDTH'(DATA_WIDTH / 8);

  loader_state_t         state, state_nxt;
  logic [ADDR_WIDTH-1:0] wptr;
  logic [CW-1:0]         count;
  logic                  room;
  logic                  accept;
  logic                  ovf_set;
  logic                  start_load;
  logic                  hold_load;
  logic                  timer_expired;

  assign room = (count < DEPTH_C);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    ovf_set    = 1'b0;
    start_load = 1'b0;
    hold_load  = 1'b0;
    case (state)
      S_IDLE, S_RUN, S_ERROR: begin
        if (i_start) begin
          state_nxt  = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (i_instr_valid) begin
          if (room) begin
            accept = 1'b1;
            if (i_instr_last) begin
              state_nxt = (RELEASE_DELAY == 0) ? S_RUN : S_HOLD;
              hold_load = 1'b1;
            end
          end else begin
            state_nxt = S_ERROR;
            ovf_set   = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (timer_expired) state_nxt = S_RUN;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write port is registered: each accepted word is written the cycle after
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_imem_we    <= 1'b0;
      o_imem_addr  <= BASE_ADDR;
      o_imem_wdata <= '0;
      wptr         <= BASE_ADDR;
      count        <= '0;
      o_overflow   <= 1'b0;
    end else begin
      o_imem_we <= accept;
      if (accept) begin
        o_imem_addr  <= wptr;
        o_imem_wdata <= i_instr_data;
        wptr         <= wptr + STEP;
        count        <= count + 1'b1;
      end
      if (start_load) begin
        wptr       <= BASE_ADDR;
        count      <= '0;
        o_overflow <= 1'b0;
      end else if (ovf_set) begin
        o_overflow <= 1'b1;
      end
    end
  end

  reset_release_timer #(
    .RELEASE_DELAY(RELEASE_DELAY)
  ) u_release_timer (
    .clk    (i_clk),
    .rst_n  (i_reset_n),
    .load   (hold_load),
    .en     (state == S_HOLD),
    .expired(timer_expired)
  );

  assign o_instr_ready = (state == S_LOAD) && room;
  assign o_cpu_reset_n = (state == S_RUN);
  assign o_done        = (state == S_RUN);
  assign o_word_count  = count;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: default instance plus a DEPTH=4 instance
// for the overflow path.
module tb_imem_loader;
  import imem_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        start, valid, last;
  logic [31:0] data;
  logic        ready, we, cpu_reset_n, done, overflow;
  logic [31:0] addr, wdata;
  logic [8:0]  count;

  logic        start4, valid4, last4;
  logic [31:0] data4;
  logic        ready4, we4, cpu_reset_n4, done4, overflow4;
  logic [31:0] addr4, wdata4;
  logic [2:0]  count4;

  imem_loader dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start),
    .i_instr_data(data), .i_instr_valid(valid), .i_instr_last(last),
    .o_instr_ready(ready), .o_imem_we(we), .o_imem_addr(addr),
    .o_imem_wdata(wdata), .o_cpu_reset_n(cpu_reset_n), .o_done(done),
    .o_overflow(overflow), .o_word_count(count)
  );

  imem_loader #(.DEPTH(4)) dut4 (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start4),
    .i_instr_data(data4), .i_instr_valid(valid4), .i_instr_last(last4),
    .o_instr_ready(ready4), .o_imem_we(we4), .o_imem_addr(addr4),
    .o_imem_wdata(wdata4), .o_cpu_reset_n(cpu_reset_n4), .o_done(done4),
    .o_overflow(overflow4), .o_word_count(count4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] wa_q[$], wd_q[$], wa4_q[$], wd4_q[$];

  always @(negedge clk) begin
    if (we === 1'b1) begin
      wa_q.push_back(addr);
      wd_q.push_back(wdata);
    end
    if (we4 === 1'b1) begin
      wa4_q.push_back(addr4);
      wd4_q.push_back(wdata4);
    end
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [31:0] w [3];
  logic [31:0] v [4];

  initial begin
    reset_n = 1'b0;
    start = 1'b0; valid = 1'b0; last = 1'b0; data = '0;
    start4 = 1'b0; valid4 = 1'b0; last4 = 1'b0; data4 = '0;
    w[0] = sw_enc(5'd20, 5'd30, 12'hFF6);
    w[1] = sw_enc(5'd1, 5'd2, 12'h004);
    w[2] = sw_enc(5'd3, 5'd2, 12'h008);
    v[0] = 32'h00A12023; v[1] = 32'h00B12223;
    v[2] = 32'h00C12423; v[3] = 32'h00D12623;
    repeat (2) tick();

    chk("rst_ready", 64'(ready), 64'(0));
    chk("rst_we", 64'(we), 64'(0));
    chk("rst_cpu_reset_n", 64'(cpu_reset_n), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_overflow", 64'(overflow), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_addr", 64'(addr), 64'(0));
    chk("rst_wdata", 64'(wdata), 64'(0));
    chk("sw_enc", 64'(w[0]), 64'(32'hFF4F2B23));

    reset_n = 1'b1;
    tick();

    // three-word program, HOLD for 3 cycles
    start = 1'b1; tick(); start = 1'b0;
    wa_q.delete(); wd_q.delete();
    chk("ready_in_load", 64'(ready), 64'(1));
    for (int i = 0; i < 3; i++) begin
      data = w[i]; valid = 1'b1; last = (i == 2); tick();
    end
    valid = 1'b0; last = 1'b0;
    chk("ready_in_hold", 64'(ready), 64'(0));
    for (int k = 0; k < 4; k++) begin
      chk("hold_done", 64'(done), 64'(k == 3));
      chk("hold_cpu_reset_n", 64'(cpu_reset_n), 64'(k == 3));
      if (k < 3) tick();
    end
    chk("count_3", 64'(count), 64'(3));
    chk("writes_3", 64'(wa_q.size()), 64'(3));
    for (int i = 0; i < 3 && i < wa_q.size(); i++) begin
      chk("addr_seq", 64'(wa_q[i]), 64'(4 * i));
      chk("data_seq", 64'(wd_q[i]), 64'(w[i]));
    end

    // valid in RUN is ignored
    data = 32'hDEADBEEF; valid = 1'b1; repeat (3) tick(); valid = 1'b0;
    chk("run_no_write", 64'(wa_q.size()), 64'(3));
    chk("run_count_kept", 64'(count), 64'(3));
    chk("run_done_kept", 64'(done), 64'(1));

    // restart from RUN, one word
    start = 1'b1; tick(); start = 1'b0;
    wa_q.delete(); wd_q.delete();
    chk("restart_cpu_reset", 64'(cpu_reset_n), 64'(0));
    chk("restart_count", 64'(count), 64'(0));
    data = w[1]; valid = 1'b1; last = 1'b1; tick();
    valid = 1'b0; last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("restart_release", 64'(cpu_reset_n), 64'(k == 3));
      if (k < 3) tick();
    end
    chk("restart_writes", 64'(wa_q.size()), 64'(1));
    if (wa_q.size() > 0) begin
      chk("restart_addr", 64'(wa_q[0]), 64'(0));
      chk("restart_data", 64'(wd_q[0]), 64'(w[1]));
    end

    // start pulse during HOLD is ignored
    start = 1'b1; tick(); start = 1'b0;
    data = w[0]; valid = 1'b1; last = 1'b0; tick();
    data = w[2]; last = 1'b1; tick();
    valid = 1'b0; last = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    chk("hold_start_done1", 64'(done), 64'(0));
    chk("hold_start_ready", 64'(ready), 64'(0));
    tick();
    chk("hold_start_done2", 64'(done), 64'(0));
    tick();
    chk("hold_start_done3", 64'(done), 64'(1));
    chk("hold_start_count", 64'(count), 64'(2));

    // valid toggling every other cycle
    start = 1'b1; tick(); start = 1'b0;
    wa_q.delete(); wd_q.delete();
    for (int i = 0; i < 8; i++) begin
      valid = ~i[0];
      data  = valid ? v[i / 2] : 32'hDEADBEEF;
      last  = (i == 6);
      tick();
    end
    valid = 1'b0; last = 1'b0;
    repeat (4) tick();
    chk("toggle_writes", 64'(wa_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < wa_q.size(); i++) begin
      chk("toggle_addr", 64'(wa_q[i]), 64'(4 * i));
      chk("toggle_data", 64'(wd_q[i]), 64'(v[i]));
    end
    chk("toggle_count", 64'(count), 64'(4));
    chk("toggle_done", 64'(done), 64'(1));

    // reset mid-session
    start = 1'b1; tick(); start = 1'b0;
    wa_q.delete(); wd_q.delete();
    data = w[0]; valid = 1'b1; last = 1'b0; tick();
    data = w[1]; tick();
    reset_n = 1'b0; valid = 1'b0;
    #1;
    chk("midrst_we", 64'(we), 64'(0));
    chk("midrst_ready", 64'(ready), 64'(0));
    chk("midrst_count", 64'(count), 64'(0));
    chk("midrst_addr", 64'(addr), 64'(0));
    chk("midrst_wdata", 64'(wdata), 64'(0));
    chk("midrst_cpu_reset_n", 64'(cpu_reset_n), 64'(0));
    chk("midrst_done", 64'(done), 64'(0));
    tick();
    reset_n = 1'b1;
    data = w[2]; valid = 1'b1; last = 1'b1;
    repeat (3) tick();
    valid = 1'b0; last = 1'b0;
    chk("postrst_ready", 64'(ready), 64'(0));
    chk("postrst_writes", 64'(wa_q.size()), 64'(1));
    chk("postrst_count", 64'(count), 64'(0));

    // overflow on the DEPTH=4 instance
    start4 = 1'b1; tick(); start4 = 1'b0;
    wa4_q.delete(); wd4_q.delete();
    for (int i = 0; i < 5; i++) begin
      data4 = 32'h100 + i; valid4 = 1'b1; last4 = 1'b0; tick();
    end
    chk("ovf_flag", 64'(overflow4), 64'(1));
    chk("ovf_cpu_reset_n", 64'(cpu_reset_n4), 64'(0));
    chk("ovf_count", 64'(count4), 64'(4));
    chk("ovf_ready", 64'(ready4), 64'(0));
    valid4 = 1'b0; tick();
    chk("ovf_writes", 64'(wa4_q.size()), 64'(4));
    for (int i = 0; i < 4 && i < wa4_q.size(); i++) begin
      chk("ovf_addr", 64'(wa4_q[i]), 64'(4 * i));
      chk("ovf_data", 64'(wd4_q[i]), 64'(32'h100 + i));
    end
    start4 = 1'b1; tick(); start4 = 1'b0;
    chk("ovf_cleared", 64'(overflow4), 64'(0));
    chk("ovf_reload_ready", 64'(ready4), 64'(1));
    chk("ovf_reload_count", 64'(count4), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
